// File: rtl/mdu_pkg.sv
// Shared CPU definitions for the multiply/divide unit: funct codes, latency defaults,
// counter width and the decoded-operation types.
package mdu_pkg;

  localparam int CNT_W           = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} md_op_e;
  typedef enum logic {IDLE, BUSY} md_state_e;

  typedef struct packed {
    logic   md;
    logic   mthi;
    logic   mtlo;
    md_op_e op;
  } md_dec_t;

  function automatic md_dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    md_dec_t d;
    d = '{md: 1'b0, mthi: 1'b0, mtlo: 1'b0, op: OP_MULT};
    if (opcode == 6'd0) begin
      case (funct)
        FN_MULT:  begin d.md = 1'b1; d.op = OP_MULT;  end
        FN_MULTU: begin d.md = 1'b1; d.op = OP_MULTU; end
        FN_DIV:   begin d.md = 1'b1; d.op = OP_DIV;   end
        FN_DIVU:  begin d.md = 1'b1; d.op = OP_DIVU;  end
        FN_MTHI:  d.mthi = 1'b1;
        FN_MTLO:  d.mtlo = 1'b1;
        default:  ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one operation,
// plus a flag marking a division by zero.
module mdu_calc
  import mdu_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, divisor, quo, rem;
  logic        is_sdiv, neg_q, neg_r;

  always_comb begin
    is_sdiv = (op == OP_DIV);
    if (op == OP_MULT)
      prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else
      prod = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes so 0x80000000 / -1 stays well defined.
    mag_a   = (is_sdiv && a[31]) ? -a : a;
    mag_b   = (is_sdiv && b[31]) ? -b : b;
    div0    = (op == OP_DIV || op == OP_DIVU) && (b == 32'd0);
    divisor = div0 ? 32'd1 : mag_b;
    quo     = mag_a / divisor;
    rem     = mag_a % divisor;
    neg_q   = is_sdiv && (a[31] ^ b[31]);
    neg_r   = is_sdiv && a[31];

    if (op == OP_MULT || op == OP_MULTU) begin
      hi = prod[63:32];
      lo = prod[31:0];
    end else begin
      hi = neg_r ? -rem : rem;
      lo = neg_q ? -quo : quo;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: accepts an operation from EX, holds busy for a
// fixed latency, then commits the pending result to the architectural HI/LO registers.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic [31:0] ins_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  output logic [31:0] HI_E,
  output logic [31:0] LO_E,
  output logic        start,
  output logic        busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_dec_t          dec;
  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi, pend_lo, calc_hi, calc_lo;
  logic             pend_div0, calc_div0;
  logic             unused_ins;

  assign dec        = decode(ins_E[31:26], ins_E[5:0]);
  assign unused_ins = ^ins_E[25:6];

  mdu_calc u_calc (
    .op   (dec.op),
    .a    (A_E),
    .b    (B_E),
    .hi   (calc_hi),
    .lo   (calc_lo),
    .div0 (calc_div0)
  );

  assign busy  = (state == BUSY);
  assign start = dec.md & ~hold & ~busy & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_div0 <= 1'b0;
      HI_E      <= '0;
      LO_E      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend_hi   <= calc_hi;
            pend_lo   <= calc_lo;
            pend_div0 <= calc_div0;
            cnt       <= (dec.op == OP_DIV || dec.op == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
            state     <= BUSY;
          end else if (!hold) begin
            if (dec.mthi) HI_E <= A_E;
            if (dec.mtlo) LO_E <= A_E;
          end
        end
        BUSY: begin
          // Counting ignores hold so the latency is fixed regardless of pipeline stalls.
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            if (!pend_div0) begin
              HI_E <= pend_hi;
              LO_E <= pend_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios followed by random operations
// compared against a plain-arithmetic HI/LO model.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                         F_DIVU = 6'b011011, F_MTHI = 6'b010001, F_MTLO = 6'b010011;

  logic        clk = 1'b0, rst = 1'b0, hold = 1'b0;
  logic [31:0] ins_E = '0, A_E = '0, B_E = '0;
  logic [31:0] HI_E, LO_E;
  logic        start, busy;

  int pass_cnt = 0, total = 0, fail_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu dut (
    .clk(clk), .rst(rst), .hold(hold), .ins_E(ins_E), .A_E(A_E), .B_E(B_E),
    .HI_E(HI_E), .LO_E(LO_E), .start(start), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_ins(input logic [5:0] fn);
    logic [31:0] r;
    r = $urandom();
    return {6'b0, r[19:0], fn};
  endfunction

  // Reference: architectural effect of an operation on HI/LO.
  task automatic ref_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (fn)
      F_MULT:  begin p = longint'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      F_MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      F_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      F_DIVU:  if (b != 0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
      default: ;
    endcase
  endtask

  task automatic run_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input bit inj_mthi);
    int n;
    logic [31:0] old_hi, old_lo;
    n = (fn == F_DIV || fn == F_DIVU) ? DC : MC;
    old_hi = m_hi;
    old_lo = m_lo;
    ins_E = mk_ins(fn); A_E = a; B_E = b; hold = 1'b0;
    #1;
    check({name, " start"}, {31'd0, start}, 32'd1);
    ref_op(fn, a, b);
    tick();
    ins_E = '0;
    for (int i = 0; i < n; i++) begin
      check({name, " busy"}, {31'd0, busy}, 32'd1);
      if (inj_mthi && i == 1) begin ins_E = mk_ins(F_MTHI); A_E = 32'hDEADBEEF; end
      else ins_E = '0;
      if (i == n - 1) begin
        check({name, " hi held"}, HI_E, old_hi);
        check({name, " lo held"}, LO_E, old_lo);
      end
      tick();
    end
    ins_E = '0;
    check({name, " done"}, {31'd0, busy}, 32'd0);
    check({name, " hi"}, HI_E, m_hi);
    check({name, " lo"}, LO_E, m_lo);
    $display("op %s a=%h b=%h -> hi=%h lo=%h", name, a, b, HI_E, LO_E);
  endtask

  task automatic mt(input logic [5:0] fn, input logic [31:0] v);
    ins_E = mk_ins(fn); A_E = v; hold = 1'b0;
    #1;
    check("mt start", {31'd0, start}, 32'd0);
    tick();
    ins_E = '0;
    if (fn == F_MTHI) m_hi = v; else m_lo = v;
    check("mt hi", HI_E, m_hi);
    check("mt lo", LO_E, m_lo);
    $display("op %s v=%h -> hi=%h lo=%h", (fn == F_MTHI) ? "mthi" : "mtlo", v, HI_E, LO_E);
  endtask

  initial begin
    logic [5:0] fns [6];
    logic [31:0] ra, rb;
    int k;
    fns = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

    // Reset state, start suppressed while reset is low
    ins_E = mk_ins(F_MULT);
    repeat (2) @(posedge clk);
    #1;
    check("rst start", {31'd0, start}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst hi", HI_E, 32'd0);
    check("rst lo", LO_E, 32'd0);
    ins_E = '0;
    rst = 1'b1;
    tick();

    run_op("mult", F_MULT, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("mult hi k", HI_E, 32'hFFFFFFFF);
    check("mult lo k", LO_E, 32'hFFFFFFFE);
    run_op("multu", F_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("multu hi k", HI_E, 32'h00000001);
    check("multu lo k", LO_E, 32'hFFFFFFFE);
    run_op("div", F_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div lo k", LO_E, 32'hFFFFFFFD);
    check("div hi k", HI_E, 32'hFFFFFFFF);
    run_op("divu", F_DIVU, 32'd7, 32'd2, 1'b0);
    check("divu lo k", LO_E, 32'd3);
    check("divu hi k", HI_E, 32'd1);

    // Division by zero leaves preset HI/LO alone
    mt(F_MTHI, 32'h12345678);
    mt(F_MTLO, 32'h12345678);
    run_op("divu0", F_DIVU, 32'd99, 32'd0, 1'b0);
    check("div0 hi k", HI_E, 32'h12345678);
    check("div0 lo k", LO_E, 32'h12345678);

    // Held mult waits for hold to drop; mthi during busy is dropped
    ins_E = mk_ins(F_MULT); A_E = 32'd3; B_E = 32'd5; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold start", {31'd0, start}, 32'd0);
      tick();
      check("hold busy", {31'd0, busy}, 32'd0);
    end
    run_op("mult hold", F_MULT, 32'd3, 32'd5, 1'b1);
    check("mthi busy k", HI_E, 32'd0);

    // Instruction frozen under hold after completion does not retrigger
    ins_E = mk_ins(F_MULT); A_E = 32'd9; B_E = 32'd9; hold = 1'b1;
    for (int i = 0; i < MC + 2; i++) begin
      #1;
      check("frozen start", {31'd0, start}, 32'd0);
      tick();
      check("frozen busy", {31'd0, busy}, 32'd0);
    end
    check("frozen lo", LO_E, m_lo);
    hold = 1'b0; ins_E = '0;
    tick();

    // Reset in the third busy cycle of a div aborts it
    ins_E = mk_ins(F_DIV); A_E = 32'd100; B_E = 32'd7;
    #1;
    check("abort start", {31'd0, start}, 32'd1);
    tick();
    ins_E = '0;
    tick();
    tick();
    check("abort busy pre", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", HI_E, 32'd0);
    check("abort lo", LO_E, 32'd0);
    m_hi = '0; m_lo = '0;
    tick();
    rst = 1'b1;
    repeat (DC + 2) tick();
    check("abort late hi", HI_E, 32'd0);
    check("abort late lo", LO_E, 32'd0);
    check("abort late busy", {31'd0, busy}, 32'd0);

    // Overflow divide then back-to-back mult
    run_op("div ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("ovf lo k", LO_E, 32'h80000000);
    check("ovf hi k", HI_E, 32'd0);
    run_op("mult b2b", F_MULT, 32'd3, 32'd4, 1'b0);
    check("b2b hi k", HI_E, 32'd0);
    check("b2b lo k", LO_E, 32'd12);

    // Random operations against the model
    for (int t = 0; t < 24; t++) begin
      k  = $urandom_range(0, 6);
      ra = $urandom();
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
      if (k < 4) run_op("rand", fns[k], ra, rb, 1'b0);
      else if (k < 6) mt(fns[k], ra);
      else begin
        ins_E = mk_ins(6'b100000); A_E = ra; B_E = rb;
        #1;
        check("nop start", {31'd0, start}, 32'd0);
        tick();
        ins_E = '0;
        check("nop hi", HI_E, m_hi);
        check("nop lo", LO_E, m_lo);
        $display("op nop -> hi=%h lo=%h", HI_E, LO_E);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
